// File: rtl/output_stream_reader.sv
// Drains one output-RAM bank per batch into an AXI4-Stream master through a
// credit-controlled first-word-fall-through FIFO, with run-time geometry.
module output_stream_reader #(
  parameter int NUM_BANKS  = 8,
  parameter int BANK_W     = 72,
  parameter int DATA_W     = 64,
  parameter int LSB_DROP   = 8,
  parameter int ADDR_W     = 13,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 16,
  localparam int BSEL_W    = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [6:0]                  cfg_width_m1,
  input  logic [6:0]                  cfg_height_m1,
  input  logic [9:0]                  cfg_batches_m1,
  input  logic [ADDR_W-1:0]           cfg_base_addr,
  input  logic                        next_batch,
  output logic                        busy,
  output logic                        batch_done,
  output logic                        read_done,
  output logic                        en_rd,
  output logic [ADDR_W-1:0]           addr_rd,
  output logic [BSEL_W-1:0]           bank_sel,
  input  logic [NUM_BANKS*BANK_W-1:0] din,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_t;

  state_t              state;
  logic [6:0]          width_m1;
  logic [6:0]          height_m1;
  logic [9:0]          batches_m1;
  logic [9:0]          batch_cnt;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [13:0]         rd_cnt;
  logic [13:0]         n_words;
  logic [ADDR_W-1:0]   n_addr;
  logic                en_last;
  logic [CNT_W-1:0]    credit_used;
  logic [CNT_W-1:0]    credit_next;

  logic [RAM_LAT-1:0]  pipe_vld;
  logic [RAM_LAT-1:0]  pipe_last;
  logic [DATA_W-1:0]   bank_word [NUM_BANKS];
  logic [DATA_W-1:0]   wr_data;
  logic                wr;
  logic                wr_last;

  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                pop;
  logic                unused_bits;

  assign n_words = (14'(width_m1) + 14'd1) * (14'(height_m1) + 14'd1);
  assign n_addr  = ADDR_W'(n_words);

  // credit_used counts reads issued but not yet popped from the FIFO, so it
  // covers both data in flight from the RAM and data already queued.
  assign pop         = m_axis_tvalid & m_axis_tready;
  assign credit_next = credit_used + CNT_W'(en_rd) - CNT_W'(pop);

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    assign bank_word[k] = din[k*BANK_W + LSB_DROP +: DATA_W];
  end

  assign unused_bits = ^din;
  assign wr_data     = bank_word[bank_sel];
  assign wr          = pipe_vld[RAM_LAT-1];
  assign wr_last     = pipe_last[RAM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      batch_done  <= 1'b0;
      read_done   <= 1'b0;
      en_rd       <= 1'b0;
      en_last     <= 1'b0;
      addr_rd     <= '0;
      bank_sel    <= '0;
      width_m1    <= '0;
      height_m1   <= '0;
      batches_m1  <= '0;
      batch_cnt   <= '0;
      ptr         <= '0;
      rd_addr     <= '0;
      rd_cnt      <= '0;
      credit_used <= '0;
    end else begin
      batch_done  <= 1'b0;
      read_done   <= 1'b0;
      en_rd       <= 1'b0;
      en_last     <= 1'b0;
      credit_used <= credit_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            width_m1   <= cfg_width_m1;
            height_m1  <= cfg_height_m1;
            batches_m1 <= cfg_batches_m1;
            ptr        <= cfg_base_addr;
            bank_sel   <= '0;
            batch_cnt  <= '0;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (next_batch) begin
            rd_addr <= ptr;
            rd_cnt  <= '0;
            state   <= S_READ;
          end
        end
        S_READ: begin
          if (credit_next < CNT_W'(FIFO_DEPTH)) begin
            en_rd   <= 1'b1;
            addr_rd <= rd_addr;
            rd_addr <= rd_addr + 1'b1;
            rd_cnt  <= rd_cnt + 14'd1;
            if (rd_cnt == n_words - 14'd1) begin
              en_last <= 1'b1;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The pointer only advances once every bank has had its batch.
          if (pop && m_axis_tlast) begin
            batch_done <= 1'b1;
            bank_sel   <= bank_sel + 1'b1;
            if (bank_sel == BSEL_W'(NUM_BANKS - 1)) ptr <= ptr + n_addr;
            if (batch_cnt == batches_m1) begin
              read_done <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              batch_cnt <= batch_cnt + 10'd1;
              state     <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= en_rd;
      pipe_last[0] <= en_last;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(wr) - CNT_W'(pop);
    end
  end

  // Head entry is gated so the stream reads all-zero whenever it is empty.
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][DATA_W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? mem[rd_ptr][DATA_W] : 1'b0;

endmodule

// File: tb/tb_output_stream_reader.sv
// Randomised self-checking bench for output_stream_reader: a job-level model
// predicts every read request and every stream beat, checked each cycle.
module tb_output_stream_reader;

  localparam int NB = 8;
  localparam int BW = 72;
  localparam int DW = 64;
  localparam int AW = 13;
  localparam int RL = 2;
  localparam int FD = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } beat_t;

  typedef struct {
    logic [2:0]    bank;
    logic [AW-1:0] addr;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    cfg_width_m1 = '0;
  logic [6:0]    cfg_height_m1 = '0;
  logic [9:0]    cfg_batches_m1 = '0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic          next_batch = 1'b0;
  logic          busy, batch_done, read_done, en_rd;
  logic [AW-1:0] addr_rd;
  logic [2:0]    bank_sel;
  logic [NB*BW-1:0] din;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  int n_checks = 0;
  int n_errors = 0;
  int en_seen = 0;
  int rd_seen = 0;
  int tready_mode = 0;

  beat_t beat_q[$];
  rd_t   rd_q[$];

  logic [RL-1:0] ram_v;
  logic [AW-1:0] ram_a [RL];

  output_stream_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width_m1(cfg_width_m1), .cfg_height_m1(cfg_height_m1),
    .cfg_batches_m1(cfg_batches_m1), .cfg_base_addr(cfg_base_addr),
    .next_batch(next_batch), .busy(busy), .batch_done(batch_done),
    .read_done(read_done), .en_rd(en_rd), .addr_rd(addr_rd),
    .bank_sel(bank_sel), .din(din), .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wordOf(input int bank, input logic [AW-1:0] addr);
    logic [15:0] mix;
    mix = {3'b000, addr} * 16'd7 + 16'h1234;
    return {8'(bank), 8'h3C, mix, 19'd0, addr};
  endfunction

  // RAM stand-in: every bank answers RL cycles after en_rd, junk otherwise.
  always @(posedge clk) begin
    ram_v[0] <= en_rd;
    ram_a[0] <= addr_rd;
    for (int i = 1; i < RL; i++) begin
      ram_v[i] <= ram_v[i-1];
      ram_a[i] <= ram_a[i-1];
    end
  end

  always_comb begin
    din = '0;
    for (int k = 0; k < NB; k++)
      din[k*BW +: BW] = ram_v[RL-1] ? {wordOf(k, ram_a[RL-1]), 8'hA5}
                                    : {8'(k), 64'hDEAD_BEEF_0BAD_F00D};
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of a whole job: bank = batch mod NB, pointer steps by N per bank sweep.
  task automatic loadJob(input int w, input int h, input int bm1, input int base);
    int n;
    logic [AW-1:0] a;
    n = (w + 1) * (h + 1);
    for (int b = 0; b <= bm1; b++) begin
      for (int i = 0; i < n; i++) begin
        a = AW'(base + (b / NB) * n + i);
        rd_q.push_back('{bank: 3'(b % NB), addr: a});
        beat_q.push_back('{data: wordOf(b % NB, a), last: (i == n - 1),
                           fin: (i == n - 1) && (b == bm1)});
      end
    end
  endtask

  task automatic applyStimulus(input int w, input int h, input int bm1, input int base);
    loadJob(w, h, bm1, base);
    checkOutput("busy_idle", busy, 0);
    cfg_width_m1   = 7'(w);
    cfg_height_m1  = 7'(h);
    cfg_batches_m1 = 10'(bm1);
    cfg_base_addr  = AW'(base);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitBatchDone();
    int k;
    k = 0;
    while (!batch_done && k < 4000) begin
      tick();
      k++;
    end
    checkOutput("batch_done_seen", batch_done, 1);
  endtask

  task automatic runBatch(input logic chk_lit, input logic [DW-1:0] lit_data, input logic lit_last);
    int k;
    tick();
    next_batch = 1'b1;
    tick();
    next_batch = 1'b0;
    checkOutput("en_rd_t1", en_rd, 0);
    tick();
    k = 2;
    checkOutput("en_rd_t2", en_rd, 1);
    while (!m_axis_tvalid && k < 64) begin
      tick();
      k++;
    end
    checkOutput("tvalid_latency", 64'(k), 64'(RL + 3));
    if (chk_lit) begin
      checkOutput("first_tdata", m_axis_tdata, lit_data);
      checkOutput("first_tlast", m_axis_tlast, lit_last);
    end
    waitBatchDone();
  endtask

  task automatic waitReads(input int base_cnt, input int n);
    int k;
    k = 0;
    while (en_seen - base_cnt < n && k < 500) begin
      tick();
      k++;
    end
    checkOutput("reads_issued", 64'(en_seen - base_cnt), 64'(n));
  endtask

  task automatic jobEmpty();
    checkOutput("reads_left", 64'(rd_q.size()), 0);
    checkOutput("beats_left", 64'(beat_q.size()), 0);
  endtask

  initial begin : tready_drv
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : compare
    beat_t b;
    rd_t   r;
    logic  stall, bd_exp, rdn_exp, st_last, hs;
    logic [DW-1:0] st_data;
    int    outst;
    stall = 0; bd_exp = 0; rdn_exp = 0; outst = 0; st_last = 0; st_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0; bd_exp = 0; rdn_exp = 0; outst = 0;
      end else begin
        checkOutput("batch_done", batch_done, bd_exp);
        checkOutput("read_done", read_done, rdn_exp);
        if (read_done) rd_seen++;
        bd_exp = 0;
        rdn_exp = 0;
        if (stall) begin
          checkOutput("stall_tvalid", m_axis_tvalid, 1);
          checkOutput("stall_tdata", m_axis_tdata, st_data);
          checkOutput("stall_tlast", m_axis_tlast, st_last);
        end
        if (en_rd) begin
          en_seen++;
          checkOutput("read_expected", 64'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            checkOutput("read_bank_addr", {bank_sel, addr_rd}, {r.bank, r.addr});
          end
        end
        hs = m_axis_tvalid && m_axis_tready;
        if (hs) begin
          checkOutput("beat_expected", 64'(beat_q.size() != 0), 1);
          if (beat_q.size() != 0) begin
            b = beat_q.pop_front();
            checkOutput("tdata", m_axis_tdata, b.data);
            checkOutput("tlast", m_axis_tlast, b.last);
            bd_exp = b.last;
            rdn_exp = b.fin;
          end
        end
        outst = outst + int'(en_rd) - int'(hs);
        checkOutput("credit_bound", 64'(outst <= FD), 1);
        stall = m_axis_tvalid && !m_axis_tready;
        st_data = m_axis_tdata;
        st_last = m_axis_tlast;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int e0;
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_en_rd", en_rd, 0);
    checkOutput("rst_addr_bank", {bank_sel, addr_rd}, 0);
    checkOutput("rst_done", {batch_done, read_done}, 0);
    checkOutput("rst_stream", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic batch");
    tready_mode = 0;
    applyStimulus(14, 5, 0, 'h100);
    runBatch(1'b1, 64'h003C_1934_0000_0100, 1'b0);
    checkOutput("basic_read_done", read_done, 1);
    tick();
    checkOutput("basic_busy_low", busy, 0);
    jobEmpty();

    $display("[TB] bank and pointer sweep");
    rd_seen = 0;
    applyStimulus(1, 0, 15, 'h1FFE);
    for (int b = 0; b < 16; b++) begin
      if (b == 7)      runBatch(1'b1, 64'h073C_F226_0000_1FFE, 1'b0);
      else if (b == 8) runBatch(1'b1, 64'h003C_1234_0000_0000, 1'b0);
      else             runBatch(1'b0, '0, 1'b0);
    end
    repeat (3) tick();
    checkOutput("sweep_read_done_once", 64'(rd_seen), 1);
    jobEmpty();

    $display("[TB] backpressure");
    tready_mode = 1;
    applyStimulus(63, 0, 0, 'h0500);
    e0 = en_seen;
    tick();
    next_batch = 1'b1;
    tick();
    next_batch = 1'b0;
    repeat (100) tick();
    checkOutput("stalled_reads", 64'(en_seen - e0), 64'(FD));
    tready_mode = 2;
    waitBatchDone();
    tready_mode = 0;
    checkOutput("bp_reads_total", 64'(en_seen - e0), 64);
    tick();
    jobEmpty();

    $display("[TB] degenerate batch");
    applyStimulus(0, 0, 0, 'h0AB);
    runBatch(1'b1, 64'h003C_16E1_0000_00AB, 1'b1);
    tick();
    jobEmpty();

    $display("[TB] ignored controls");
    tready_mode = 1;
    applyStimulus(9, 0, 1, 'h40);
    e0 = en_seen;
    tick();
    next_batch = 1'b1;
    tick();
    next_batch = 1'b0;
    tick();
    cfg_width_m1 = 7'd2;
    cfg_base_addr = AW'('h777);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitReads(e0, 10);
    repeat (2) tick();
    next_batch = 1'b1;
    tick();
    next_batch = 1'b0;
    tready_mode = 0;
    waitBatchDone();
    repeat (10) tick();
    checkOutput("no_extra_batch", 64'(en_seen - e0), 10);
    checkOutput("still_busy", busy, 1);
    runBatch(1'b0, '0, 1'b0);
    checkOutput("ignored_read_done", read_done, 1);
    tick();
    jobEmpty();

    $display("[TB] reset during drain");
    tready_mode = 1;
    applyStimulus(7, 0, 0, 'h200);
    e0 = en_seen;
    tick();
    next_batch = 1'b1;
    tick();
    next_batch = 1'b0;
    waitReads(e0, 8);
    repeat (2) tick();
    checkOutput("pre_reset_tvalid", m_axis_tvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset_tvalid", m_axis_tvalid, 0);
    checkOutput("reset_en_rd", en_rd, 0);
    checkOutput("reset_busy", busy, 0);
    beat_q.delete();
    rd_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tready_mode = 0;
    tick();
    applyStimulus(3, 1, 0, 'h030);
    runBatch(1'b0, '0, 1'b0);
    checkOutput("post_reset_read_done", read_done, 1);
    repeat (3) tick();
    jobEmpty();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_stream_reader.md
# output_stream_reader

Parametrised successor to the fixed-geometry output-buffer reader. It drains one bank of the banked output RAM per batch and packs the data into an AXI4-Stream master. A credit-controlled internal FIFO sits in between, so the stream never overflows under any backpressure. It sits between the output buffer banks and the DMA (S2MM) stream, and takes its geometry, batch count and base address at run time instead of per-layer constants.

## Interface
- NUM_BANKS, 8, number of output RAM banks (power of two, ≥2)
- BANK_W, 72, width of one bank read word
- DATA_W, 64, stream width; bank slice is din[LSB_DROP+DATA_W-1:LSB_DROP]
- LSB_DROP, 8, low bank bits discarded (LSB_DROP+DATA_W ≤ BANK_W)
- ADDR_W, 13, bank address width
- RAM_LAT, 2, cycles from en_rd/addr_rd to valid din (≥1)
- FIFO_DEPTH, 16, internal FIFO entries (power of two, > RAM_LAT+2)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  job start pulse, sampled only in IDLE
- cfg_width_m1  in  7  words per row minus 1, latched at start
- cfg_height_m1  in  7  rows per batch minus 1, latched at start
- cfg_batches_m1  in  10  total batches minus 1, latched at start
- cfg_base_addr  in  ADDR_W  first read address, latched at start
- next_batch  in  1  permission to read next batch, sampled only in WAIT
- busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse when a batch's tlast beat is accepted
- read_done  out  1  one-cycle pulse with the final batch_done
- en_rd  out  1  bank read enable
- addr_rd  out  ADDR_W  bank read address
- bank_sel  out  log2(NUM_BANKS)  bank currently read
- din  in  NUM_BANKS*BANK_W  all bank outputs; bank k at [k*BANK_W +: BANK_W]
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  stream valid
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tlast  out  1  last word of batch

## Operation
- Batch size: N = (cfg_width_m1+1)*(cfg_height_m1+1) words, computed in 14 bits.
- State IDLE: waits for start. On start it latches the cfg inputs, clears bank_sel and sets the address pointer to cfg_base_addr, then goes to WAIT.
- State WAIT: on next_batch goes to READ.
- State READ: issues N reads from bank bank_sel at ptr, ptr+1, … ptr+N-1, then goes to DRAIN.
- State DRAIN: waits for the tlast beat to be accepted. Then:
  - batch_done pulses.
  - bank_sel increments, mod NUM_BANKS.
  - When bank_sel wraps 7→0 (generally NUM_BANKS-1→0), ptr += N, mod 2^ADDR_W. Otherwise ptr is unchanged.
  - If this was batch cfg_batches_m1, read_done pulses and the FSM goes to IDLE. Otherwise it goes to WAIT.
- Credit rule: en_rd may be high only when (reads in flight + FIFO occupancy) < FIFO_DEPTH. The FIFO never overflows and no read data is ever dropped.
- Data capture: the returned word is taken from bank bank_sel, bits [LSB_DROP+DATA_W-1:LSB_DROP], and written into the FIFO RAM_LAT cycles after its en_rd.
- Output: the FIFO is first-word-fall-through.
  - m_axis_tvalid = FIFO not empty.
  - tdata and tlast come from the head entry.
  - tlast is stored alongside the word when it is the Nth word of the batch.
- Address arithmetic: wraps mod 2^ADDR_W with no error.
- Ignored inputs: start outside IDLE and next_batch outside WAIT are ignored.

## Timing
- Reset: asynchronous assertion clears everything immediately; release is synchronous to clk.
  - State = IDLE.
  - All outputs 0: busy, batch_done, read_done, en_rd, addr_rd, bank_sel, m_axis_tvalid, m_axis_tdata, m_axis_tlast.
  - FIFO empty, credits and counters cleared.
- Reset mid-batch: the stream drops immediately with no tlast, and partial data is discarded.
- start at cycle t: busy is high at t+1.
- next_batch at t (in WAIT): first en_rd at t+2. First m_axis_tvalid at t+3+RAM_LAT, with tready held high.
- Throughput: one read per cycle while credits remain. One beat per cycle while tready=1.
- Backpressure: when tready is held low, en_rd stops after exactly FIFO_DEPTH words are outstanding.
- AXIS rules:
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake, except on reset.
- batch_done and read_done are registered and pulse in the cycle after the tlast handshake.
- Back-to-back batches: if next_batch is already high in the WAIT cycle, the next batch's first en_rd occurs 3 cycles after the tlast handshake.

## Test plan
- Basic batch: width_m1=14, height_m1=5, batches_m1=0, base=0x100, RAM model returns addr, tready=1.
  - Required: 90 beats, tdata = addr 0x100..0x159 from bank 0, tlast only on beat 90.
  - Then batch_done and read_done pulse together, and busy falls.
- Bank/pointer sweep: width_m1=1, height_m1=0, batches_m1=15, base=0x1FFE, ADDR_W=13.
  - Required: batches 0-7 read banks 0..7 at 0x1FFE, 0x1FFF.
  - Batches 8-15 read banks 0..7 at 0x0000, 0x0001 (address wrap).
  - read_done pulses exactly once, after the 16th batch_done.
- Backpressure: width_m1=63, height_m1=0, tready=0 for 100 cycles, then random tready.
  - Required: en_rd count stops at 16 while stalled, and there is no FIFO overflow.
  - All 64 words arrive in order, with tdata stable during stalls.
- Degenerate batch: width_m1=0, height_m1=0.
  - Required: a single beat with tlast=1.
  - Latency from next_batch to tvalid is RAM_LAT+3.
- Ignored controls: pulse start during READ and next_batch during DRAIN.
  - Required: no config change and no extra batch.
- Reset mid-DRAIN with tvalid high.
  - Required: tvalid, en_rd and busy read 0 immediately.
  - After release, a fresh start runs a clean batch from bank 0.
